// File: rtl/hazard_track_unit.sv
// rtl/hazard_track_unit.sv - in-flight instruction tracker deciding issue, stall, kill and redirect for ID
// Shadows the pipeline from EX onward so hazards are resolved without peeking at datapath registers.
module hazard_track_unit #(
    parameter int NREG       = 32,
    parameter int NSTG       = 3,
    parameter int FWD_EN     = 1,
    parameter int LOAD_DIST  = 1,
    parameter int NOFWD_DIST = 3,
    parameter int BR_STAGE   = 2,
    parameter int BR_MODE    = 0,
    parameter int AW         = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic            id_wr_en,
    input  logic [AW-1:0]   id_wr_reg,
    input  logic            id_is_load,
    input  logic            id_is_ctrl,
    input  logic            br_taken,
    output logic            pc_en,
    output logic            pc_redirect,
    output logic            ifid_en,
    output logic            ifid_flush,
    output logic            idex_bubble,
    output logic [NSTG-1:0] stg_flush,
    output logic [31:0]     stall_cycles,
    output logic [31:0]     flush_events
);

    // Tracker entry k lives at index k-1.
    logic [NSTG-1:0] entV;
    logic [NSTG-1:0] entWr;
    logic [NSTG-1:0] entLd;
    logic [NSTG-1:0] entCtl;
    logic [AW-1:0]   entRd [NSTG];

    logic [NSTG-1:0] srcHit;
    logic            hazard;
    logic            ctrlPre;
    logic            ctrlAt;
    logic            ctrlIdIssue;
    logic            flush;
    logic            dataStall;
    logic            issue;

    always_comb begin
        srcHit = '0;
        hazard = 1'b0;
        for (int k = 1; k <= NSTG; k++) begin
            srcHit[k-1] = entV[k-1] && entWr[k-1] &&
                ((id_use_rs && (id_rs != '0) && (entRd[k-1] == id_rs)) ||
                 (id_use_rt && (id_rt != '0) && (entRd[k-1] == id_rt)));
            if (FWD_EN != 0) begin
                if (srcHit[k-1] && entLd[k-1] && (k <= LOAD_DIST)) begin
                    hazard = 1'b1;
                end
            end else begin
                if (srcHit[k-1] && (k <= NOFWD_DIST)) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        ctrlPre = 1'b0;
        for (int k = 1; k < BR_STAGE; k++) begin
            ctrlPre = ctrlPre | (entV[k-1] & entCtl[k-1]);
        end
    end

    assign ctrlAt      = entV[BR_STAGE-1] & entCtl[BR_STAGE-1];
    assign flush       = (BR_MODE == 1) && ctrlAt && br_taken;
    assign dataStall   = hazard && id_valid && !flush;
    assign issue       = id_valid && !dataStall && !flush;
    assign ctrlIdIssue = issue && id_is_ctrl;

    always_comb begin
        stg_flush = '0;
        for (int k = 1; k <= NSTG; k++) begin
            stg_flush[k-1] = flush && (k < BR_STAGE);
        end
    end

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        pc_redirect = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        if (BR_MODE == 1) begin
            if (flush) begin
                pc_redirect = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (dataStall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end
        end else begin
            if (dataStall) begin
                pc_en       = 1'b0;
                ifid_en     = 1'b0;
                idex_bubble = 1'b1;
            end else begin
                if (ctrlIdIssue || ctrlPre) begin
                    pc_en = 1'b0;
                end
                if (ctrlIdIssue || ctrlPre || ctrlAt) begin
                    ifid_flush = 1'b1;
                end
            end
            // A resolving branch always loads the target so it is never lost behind a stall.
            if (ctrlAt) begin
                pc_redirect = 1'b1;
                pc_en       = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            entV   <= '0;
            entWr  <= '0;
            entLd  <= '0;
            entCtl <= '0;
            for (int k = 0; k < NSTG; k++) begin
                entRd[k] <= '0;
            end
        end else begin
            entV[0]   <= issue;
            entWr[0]  <= id_wr_en;
            entRd[0]  <= id_wr_reg;
            entLd[0]  <= id_is_load;
            entCtl[0] <= id_is_ctrl;
            for (int k = 1; k < NSTG; k++) begin
                entV[k]   <= entV[k-1] & ~stg_flush[k-1];
                entWr[k]  <= entWr[k-1];
                entRd[k]  <= entRd[k-1];
                entLd[k]  <= entLd[k-1];
                entCtl[k] <= entCtl[k-1];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (dataStall) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (flush) begin
                flush_events <= flush_events + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_track_unit.sv
// tb/tb_hazard_track_unit.sv - bench for hazard_track_unit across forwarding and branch-mode variants
module tb_hazard_track_unit;

    localparam int NSTG       = 3;
    localparam int LOAD_DIST  = 1;
    localparam int NOFWD_DIST = 3;
    localparam int BR_STAGE   = 2;
    localparam int HLEN       = 1024;

    // Observation vector: {pc_en, ifid_en, pc_redirect, ifid_flush, idex_bubble, stg_flush[2:0]}
    localparam logic [7:0] DEF    = 8'b1100_0000;
    localparam logic [7:0] STALL  = 8'b0000_1000;
    localparam logic [7:0] CSTALL = 8'b0101_0000;
    localparam logic [7:0] CREDIR = 8'b1111_0000;
    localparam logic [7:0] FLUSH  = 8'b1111_1001;

    typedef struct packed {
        logic       v;
        logic       wr;
        logic [4:0] rd;
        logic       ld;
        logic       ctl;
    } instT;

    logic       clk;
    logic       rst;
    logic       idValid;
    logic [4:0] idRs;
    logic [4:0] idRt;
    logic       idUseRs;
    logic       idUseRt;
    logic       idWrEn;
    logic [4:0] idWrReg;
    logic       idIsLoad;
    logic       idIsCtrl;
    logic       brTaken;

    logic [2:0]  pcEn;
    logic [2:0]  pcRedir;
    logic [2:0]  ifidEn;
    logic [2:0]  ifidFlush;
    logic [2:0]  idexBubble;
    logic [2:0]  stgF     [3];
    logic [31:0] stallCnt [3];
    logic [31:0] flushCnt [3];

    int checks;
    int failures;

    // Model: instruction issued at cycle n sits in stage (now - n).
    instT hist [3][HLEN];
    int   cyc;
    int   expStall [3];
    int   expFlush [3];
    bit   cfgFwd [3] = '{1'b1, 1'b0, 1'b1};
    bit   cfgBrm [3] = '{1'b0, 1'b0, 1'b1};

    // 0: forwarding + stall-on-branch, 1: no forwarding + stall-on-branch, 2: forwarding + predict not-taken
    for (genvar g = 0; g < 3; g++) begin : gDut
        hazard_track_unit #(
            .FWD_EN  ((g == 1) ? 0 : 1),
            .BR_MODE ((g == 2) ? 1 : 0)
        ) dut (
            .clk          (clk),
            .rst          (rst),
            .id_valid     (idValid),
            .id_rs        (idRs),
            .id_rt        (idRt),
            .id_use_rs    (idUseRs),
            .id_use_rt    (idUseRt),
            .id_wr_en     (idWrEn),
            .id_wr_reg    (idWrReg),
            .id_is_load   (idIsLoad),
            .id_is_ctrl   (idIsCtrl),
            .br_taken     (brTaken),
            .pc_en        (pcEn[g]),
            .pc_redirect  (pcRedir[g]),
            .ifid_en      (ifidEn[g]),
            .ifid_flush   (ifidFlush[g]),
            .idex_bubble  (idexBubble[g]),
            .stg_flush    (stgF[g]),
            .stall_cycles (stallCnt[g]),
            .flush_events (flushCnt[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] obs(input int c);
        return {pcEn[c], ifidEn[c], pcRedir[c], ifidFlush[c], idexBubble[c], stgF[c]};
    endfunction

    task automatic setIdle();
        idValid  = 1'b0;
        idRs     = '0;
        idRt     = '0;
        idUseRs  = 1'b0;
        idUseRt  = 1'b0;
        idWrEn   = 1'b0;
        idWrReg  = '0;
        idIsLoad = 1'b0;
        idIsCtrl = 1'b0;
    endtask

    task automatic setInst(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                           input bit we, input int wreg, input bit ld, input bit ctl);
        idValid  = v;
        idRs     = 5'(rs);
        idRt     = 5'(rt);
        idUseRs  = urs;
        idUseRt  = urt;
        idWrEn   = we;
        idWrReg  = 5'(wreg);
        idIsLoad = ld;
        idIsCtrl = ctl;
    endtask

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst     = 1'b1;
        brTaken = 1'b0;
        setIdle();
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        brTaken = 1'b0;
        setIdle();
        #3;
        for (int c = 0; c < 3; c++) begin
            if (obs(c) !== DEF) begin
                failures++;
                $display("FAIL reset_outputs dut%0d got=%b exp=%b", c, obs(c), DEF);
            end
            checks++;
            if (stallCnt[c] !== 32'd0 || flushCnt[c] !== 32'd0) begin
                failures++;
                $display("FAIL reset_counters dut%0d got=%0d/%0d exp=0/0", c, stallCnt[c], flushCnt[c]);
            end
            checks++;
        end
        nextCycle();
        rst = 1'b0;
    endtask

    task automatic test_nofwd_stall();
        doReset();
        setInst(1, 1, 2, 1, 1, 1, 3, 0, 0);
        #3;
        for (int c = 0; c < 3; c++) begin
            if (obs(c) !== DEF) begin
                failures++;
                $display("FAIL nofwd_producer dut%0d got=%b exp=%b", c, obs(c), DEF);
            end
            checks++;
        end
        nextCycle();
        setInst(1, 3, 1, 1, 1, 1, 4, 0, 0);
        for (int i = 1; i <= 4; i++) begin
            #3;
            if (obs(1) !== ((i <= 3) ? STALL : DEF)) begin
                failures++;
                $display("FAIL nofwd_consumer cyc%0d got=%b exp=%b", i, obs(1), (i <= 3) ? STALL : DEF);
            end
            checks++;
            if (obs(0) !== DEF) begin
                failures++;
                $display("FAIL fwd_add_no_stall cyc%0d got=%b exp=%b", i, obs(0), DEF);
            end
            checks++;
            nextCycle();
        end
        #3;
        if (stallCnt[1] !== 32'd3 || stallCnt[0] !== 32'd0) begin
            failures++;
            $display("FAIL nofwd_stall_count got=%0d/%0d exp=3/0", stallCnt[1], stallCnt[0]);
        end
        checks++;
    endtask

    task automatic test_load_use();
        doReset();
        setInst(1, 1, 0, 1, 0, 1, 5, 1, 0);
        #3;
        if (obs(0) !== DEF) begin
            failures++;
            $display("FAIL load_issue got=%b exp=%b", obs(0), DEF);
        end
        checks++;
        nextCycle();
        setInst(1, 5, 1, 1, 1, 1, 6, 0, 0);
        for (int i = 1; i <= 2; i++) begin
            #3;
            for (int c = 0; c < 3; c += 2) begin
                if (obs(c) !== ((i == 1) ? STALL : DEF)) begin
                    failures++;
                    $display("FAIL load_use dut%0d cyc%0d got=%b exp=%b", c, i, obs(c), (i == 1) ? STALL : DEF);
                end
                checks++;
            end
            nextCycle();
        end
        #3;
        if (stallCnt[0] !== 32'd1 || stallCnt[2] !== 32'd1) begin
            failures++;
            $display("FAIL load_use_count got=%0d/%0d exp=1/1", stallCnt[0], stallCnt[2]);
        end
        checks++;
    endtask

    task automatic test_r0_and_unused();
        doReset();
        setInst(1, 1, 2, 1, 1, 1, 0, 1, 0);
        for (int i = 0; i < 8; i++) begin
            if (i == 1) setInst(1, 0, 0, 1, 1, 1, 4, 0, 0);
            if (i == 4) setInst(1, 1, 2, 1, 1, 1, 9, 1, 0);
            if (i == 5) setInst(1, 1, 9, 1, 0, 1, 10, 0, 0);
            #3;
            for (int c = 0; c < 2; c++) begin
                if (obs(c) !== DEF) begin
                    failures++;
                    $display("FAIL r0_unused dut%0d step%0d got=%b exp=%b", c, i, obs(c), DEF);
                end
                checks++;
            end
            nextCycle();
        end
    endtask

    task automatic test_branch_stall();
        for (int t = 0; t < 2; t++) begin
            doReset();
            brTaken = t[0];
            setInst(1, 1, 2, 1, 1, 0, 0, 0, 1);
            for (int i = 0; i < 4; i++) begin
                if (i == 1) setIdle();
                #3;
                for (int c = 0; c < 2; c++) begin
                    if (obs(c) !== ((i < 2) ? CSTALL : (i == 2) ? CREDIR : DEF)) begin
                        failures++;
                        $display("FAIL branch_stall dut%0d taken%0d t+%0d got=%b exp=%b", c, t, i, obs(c),
                                 (i < 2) ? CSTALL : (i == 2) ? CREDIR : DEF);
                    end
                    checks++;
                end
                if (obs(2) !== ((i == 2 && t == 1) ? FLUSH : DEF)) begin
                    failures++;
                    $display("FAIL predict_nt taken%0d t+%0d got=%b exp=%b", t, i, obs(2),
                             (i == 2 && t == 1) ? FLUSH : DEF);
                end
                checks++;
                nextCycle();
            end
            #3;
            if (flushCnt[2] !== 32'(t) || flushCnt[0] !== 32'd0 || stallCnt[0] !== 32'd0) begin
                failures++;
                $display("FAIL branch_counters taken%0d got=%0d/%0d/%0d exp=%0d/0/0", t,
                         flushCnt[2], flushCnt[0], stallCnt[0], t);
            end
            checks++;
        end
    endtask

    task automatic test_branch_flush();
        doReset();
        setInst(1, 1, 2, 1, 1, 0, 0, 0, 1);
        #3;
        if (obs(2) !== DEF) begin
            failures++;
            $display("FAIL flush_beq_issue got=%b exp=%b", obs(2), DEF);
        end
        checks++;
        nextCycle();
        setInst(1, 1, 2, 1, 1, 1, 7, 0, 0);
        #3;
        if (obs(2) !== DEF) begin
            failures++;
            $display("FAIL flush_add_issue got=%b exp=%b", obs(2), DEF);
        end
        checks++;
        nextCycle();
        brTaken = 1'b1;
        setInst(1, 1, 2, 1, 1, 1, 7, 1, 0);
        #3;
        if (obs(2) !== FLUSH) begin
            failures++;
            $display("FAIL flush_taken got=%b exp=%b", obs(2), FLUSH);
        end
        checks++;
        nextCycle();
        brTaken = 1'b0;
        setInst(1, 7, 7, 1, 1, 1, 8, 0, 0);
        #3;
        if (obs(2) !== DEF) begin
            failures++;
            $display("FAIL flush_killed_reader got=%b exp=%b", obs(2), DEF);
        end
        checks++;
        if (flushCnt[2] !== 32'd1 || stallCnt[2] !== 32'd0) begin
            failures++;
            $display("FAIL flush_counters got=%0d/%0d exp=1/0", flushCnt[2], stallCnt[2]);
        end
        checks++;
        nextCycle();
    endtask

    task automatic test_reset_midop();
        doReset();
        setInst(1, 1, 2, 1, 1, 1, 5, 1, 0);
        nextCycle();
        setInst(1, 1, 2, 1, 1, 1, 6, 1, 0);
        nextCycle();
        setInst(1, 6, 0, 1, 0, 1, 9, 0, 0);
        #3;
        if (obs(0) !== STALL || obs(1) !== STALL) begin
            failures++;
            $display("FAIL midop_prestall got=%b/%b exp=%b", obs(0), obs(1), STALL);
        end
        checks++;
        nextCycle();
        #3;
        if (obs(1) !== STALL || stallCnt[0] !== 32'd1 || stallCnt[1] !== 32'd1) begin
            failures++;
            $display("FAIL midop_before_reset got=%b cnt=%0d/%0d exp=%b cnt=1/1", obs(1),
                     stallCnt[0], stallCnt[1], STALL);
        end
        checks++;
        #1;
        rst = 1'b1;
        #1;
        for (int c = 0; c < 3; c++) begin
            if (obs(c) !== DEF || stallCnt[c] !== 32'd0 || flushCnt[c] !== 32'd0) begin
                failures++;
                $display("FAIL midop_async_reset dut%0d got=%b cnt=%0d/%0d exp=%b cnt=0/0", c, obs(c),
                         stallCnt[c], flushCnt[c], DEF);
            end
            checks++;
        end
        nextCycle();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #3;
            if (obs(1) !== DEF || stallCnt[1] !== 32'd0) begin
                failures++;
                $display("FAIL midop_after_release step%0d got=%b cnt=%0d exp=%b cnt=0", i, obs(1),
                         stallCnt[1], DEF);
            end
            checks++;
            nextCycle();
        end
    endtask

    task automatic modelEval(input int c, output logic [7:0] o, output bit iss, output bit fl, output bit st);
        instT e;
        bit   hz;
        bit   ctlBefore;
        bit   ctlAt;
        bit   ctrlId;
        bit   pcE;
        int   lim;
        hz        = 1'b0;
        ctlBefore = 1'b0;
        ctlAt     = 1'b0;
        for (int k = 1; k <= NSTG; k++) begin
            e = (cyc >= k) ? hist[c][cyc-k] : '0;
            if (e.v && e.wr && ((idUseRs && idRs != 0 && e.rd == idRs) ||
                                (idUseRt && idRt != 0 && e.rd == idRt))) begin
                lim = cfgFwd[c] ? (e.ld ? LOAD_DIST : 0) : NOFWD_DIST;
                if (k <= lim) hz = 1'b1;
            end
            if (e.v && e.ctl && k < BR_STAGE) ctlBefore = 1'b1;
            if (e.v && e.ctl && k == BR_STAGE) ctlAt = 1'b1;
        end
        fl     = cfgBrm[c] && ctlAt && brTaken;
        st     = idValid && hz && !fl;
        iss    = idValid && !st && !fl;
        ctrlId = iss && idIsCtrl;
        if (fl) begin
            o = FLUSH;
        end else if (st) begin
            pcE = !cfgBrm[c] && ctlAt;
            o   = {pcE, 1'b0, pcE, 1'b0, 1'b1, 3'b000};
        end else if (!cfgBrm[c]) begin
            pcE = ctlAt || !(ctrlId || ctlBefore);
            o   = {pcE, 1'b1, ctlAt, (ctrlId || ctlBefore || ctlAt), 1'b0, 3'b000};
        end else begin
            o = DEF;
        end
    endtask

    task automatic test_random();
        logic [7:0] o;
        bit         iss;
        bit         fl;
        bit         st;
        doReset();
        cyc = 0;
        for (int c = 0; c < 3; c++) begin
            expStall[c] = 0;
            expFlush[c] = 0;
            for (int n = 0; n < HLEN; n++) hist[c][n] = '0;
        end
        for (int i = 0; i < 800; i++) begin
            setInst($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 7),
                    $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 2) != 0,
                    $urandom_range(0, 7), $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
            brTaken = $urandom_range(0, 1) == 1;
            #3;
            for (int c = 0; c < 3; c++) begin
                modelEval(c, o, iss, fl, st);
                if (obs(c) !== o) begin
                    failures++;
                    $display("FAIL random_outputs dut%0d cyc%0d got=%b exp=%b", c, cyc, obs(c), o);
                end
                checks++;
                if (stallCnt[c] !== 32'(expStall[c]) || flushCnt[c] !== 32'(expFlush[c])) begin
                    failures++;
                    $display("FAIL random_counters dut%0d cyc%0d got=%0d/%0d exp=%0d/%0d", c, cyc,
                             stallCnt[c], flushCnt[c], expStall[c], expFlush[c]);
                end
                checks++;
                hist[c][cyc] = iss ? {1'b1, idWrEn, idWrReg, idIsLoad, idIsCtrl} : '0;
                if (fl) begin
                    for (int k = 1; k < BR_STAGE; k++) begin
                        if (cyc >= k) hist[c][cyc-k].v = 1'b0;
                    end
                end
                expStall[c] += st ? 1 : 0;
                expFlush[c] += fl ? 1 : 0;
            end
            cyc++;
            nextCycle();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_nofwd_stall();
        test_load_use();
        test_r0_and_unused();
        test_branch_stall();
        test_branch_flush();
        test_reset_midop();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
